sdram_port_arbiter: RTL and testbench

// Parametrised multi-channel burst scheduler in front of the SDRAM command path. Tracks per-channel

---
 rtl/sdram_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Multi-channel SDRAM burst scheduler: tracks per-channel burst address/length/wrap for read and
// write FIFO channels, arbitrates (fixed or round-robin) and issues one burst request per grant.
module sdram_port_arbiter #(
  parameter int NRD        = 2,
  parameter int NWR        = 2,
  parameter int ASIZE      = 23,
  parameter int LSIZE      = 9,
  parameter int DEF_LENGTH = 128,
  parameter int DEF_MAX    = 384000,
  parameter int RR_MODE    = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NRD-1:0]         RD_LOAD,
  input  logic [NRD*ASIZE-1:0]   RD_START_ADDR,
  input  logic [NRD*ASIZE-1:0]   RD_MAX_ADDR,
  input  logic [NRD*LSIZE-1:0]   RD_LENGTH,
  input  logic [NRD*16-1:0]      RD_LEVEL,
  input  logic [NWR-1:0]         WR_LOAD,
  input  logic [NWR*ASIZE-1:0]   WR_START_ADDR,
  input  logic [NWR*ASIZE-1:0]   WR_MAX_ADDR,
  input  logic [NWR*LSIZE-1:0]   WR_LENGTH,
  input  logic [NWR*16-1:0]      WR_LEVEL,
  output logic                   REQ,
  output logic                   REQ_WRITE,
  output logic [ASIZE-1:0]       REQ_ADDR,
  output logic [LSIZE-1:0]       REQ_LENGTH,
  input  logic                   REQ_ACK,
  input  logic                   REQ_DONE,
  output logic [NRD-1:0]         RD_GNT,
  output logic [NWR-1:0]         WR_GNT,
  output logic [1:0]             FSM_STATE
);

  localparam int NCH = NRD + NWR;
  localparam int IW  = $clog2(NCH);
  localparam int LW  = (LSIZE > 16) ? LSIZE : 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  logic [1:0]       state;
  logic [ASIZE-1:0] ch_addr  [NCH];
  logic [ASIZE-1:0] ch_start [NCH];
  logic [ASIZE-1:0] ch_max   [NCH];
  logic [LSIZE-1:0] ch_len   [NCH];
  logic [ASIZE-1:0] ld_start [NCH];
  logic [ASIZE-1:0] ld_max   [NCH];
  logic [LSIZE-1:0] ld_len   [NCH];
  logic [LW-1:0]    lvl      [NCH];
  logic [ASIZE-1:0] nxt_addr [NCH];
  logic [ASIZE:0]   sum;
  logic [NCH-1:0]   ld, elig, adv, gnt;
  logic [IW-1:0]    ptr, gsel, sel;
  logic             found, any_ld, load_hit, done_now;
  int               cand;

  // Flatten read and write channels into one index space: reads 0..NRD-1, writes NRD..NCH-1.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      ld[i]       = RD_LOAD[i];
      ld_start[i] = RD_START_ADDR[i*ASIZE +: ASIZE];
      ld_max[i]   = RD_MAX_ADDR[i*ASIZE +: ASIZE];
      ld_len[i]   = RD_LENGTH[i*LSIZE +: LSIZE];
      lvl[i]      = LW'(RD_LEVEL[i*16 +: 16]);
    end
    for (int j = 0; j < NWR; j++) begin
      ld[NRD+j]       = WR_LOAD[j];
      ld_start[NRD+j] = WR_START_ADDR[j*ASIZE +: ASIZE];
      ld_max[NRD+j]   = WR_MAX_ADDR[j*ASIZE +: ASIZE];
      ld_len[NRD+j]   = WR_LENGTH[j*LSIZE +: LSIZE];
      lvl[NRD+j]      = LW'(WR_LEVEL[j*16 +: 16]);
    end
  end

  // Reads need room for a full burst, writes need a full burst of data.
  always_comb begin
    sum = '0;
    for (int c = 0; c < NCH; c++) begin
      if (c < NRD) elig[c] = (lvl[c] <  LW'(ch_len[c])) && (ch_len[c] != '0) && !ld[c];
      else         elig[c] = (lvl[c] >= LW'(ch_len[c])) && (ch_len[c] != '0) && !ld[c];
      sum         = {1'b0, ch_addr[c]} + (ASIZE+1)'(ch_len[c]);
      nxt_addr[c] = (sum < {1'b0, ch_max[c]}) ? sum[ASIZE-1:0] : ch_start[c];
      adv[c]      = done_now && !load_hit && (gsel == IW'(c));
    end
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    for (int k = 1; k <= NCH; k++) begin
      cand = (RR_MODE != 0) ? int'(ptr) + k : k - 1;
      if (cand >= NCH) cand = cand - NCH;
      if (!found && elig[cand[IW-1:0]]) begin
        found = 1'b1;
        sel   = cand[IW-1:0];
      end
    end
  end

  assign any_ld    = |ld;
  assign done_now  = ((state == ST_ISSUE) && REQ_ACK && REQ_DONE) || ((state == ST_BUSY) && REQ_DONE);
  assign RD_GNT    = gnt[NRD-1:0];
  assign WR_GNT    = gnt[NCH-1:NRD];
  assign FSM_STATE = state;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int c = 0; c < NCH; c++) begin
        ch_addr[c]  <= '0;
        ch_start[c] <= '0;
        ch_max[c]   <= ASIZE'(DEF_MAX);
        ch_len[c]   <= LSIZE'(DEF_LENGTH);
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (ld[c]) begin
          ch_addr[c]  <= ld_start[c];
          ch_start[c] <= ld_start[c];
          ch_max[c]   <= ld_max[c];
          ch_len[c]   <= ld_len[c];
        end else if (adv[c]) begin
          ch_addr[c]  <= nxt_addr[c];
        end
      end
    end
  end

  // REQ is a valid held with stable fields until the controller raises REQ_ACK (ready);
  // the transfer happens on the edge where both are high, REQ_DONE later closes the burst.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      REQ        <= 1'b0;
      REQ_WRITE  <= 1'b0;
      REQ_ADDR   <= '0;
      REQ_LENGTH <= '0;
      gnt        <= '0;
      gsel       <= '0;
      ptr        <= '0;
      load_hit   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found && !any_ld) begin
            state      <= ST_ISSUE;
            REQ        <= 1'b1;
            REQ_WRITE  <= (int'(sel) >= NRD);
            REQ_ADDR   <= ch_addr[sel];
            REQ_LENGTH <= ch_len[sel];
            gnt        <= NCH'(1) << sel;
            gsel       <= sel;
            ptr        <= sel;
            load_hit   <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (ld[gsel]) load_hit <= 1'b1;
          if (REQ_ACK) begin
            REQ <= 1'b0;
            if (REQ_DONE) begin
              state <= ST_IDLE;
              gnt   <= '0;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (ld[gsel]) load_hit <= 1'b1;
          if (REQ_DONE) begin
            state <= ST_IDLE;
            gnt   <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: randomized bursts checked against a queue-based
// reference model of channel addresses, eligibility and arbitration order.
module tb_sdram_port_arbiter;
  localparam int NCH = 4;
  localparam int EW  = 37;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rd_load, wr_load;
  logic [45:0] rd_start, rd_max, wr_start, wr_max;
  logic [17:0] rd_len, wr_len;
  logic [31:0] rd_level, wr_level;
  logic        ack1, done1, ack0, done0;
  logic        req, req_write, req0, req_write0;
  logic [22:0] req_addr, req_addr0;
  logic [8:0]  req_length, req_length0;
  logic [1:0]  rd_gnt, wr_gnt, rd_gnt0, wr_gnt0, fsm_state, fsm_state0;

  int n_chk, n_pass;
  int m_addr[NCH], m_start[NCH], m_max[NCH], m_len[NCH], lvl[NCH];
  int m_ptr;
  int ch, a;
  int exp_order[5] = '{0, 1, 2, 3, 0};
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  sdram_port_arbiter dut (
    .CLK(clk), .RESET(rst),
    .RD_LOAD(rd_load), .RD_START_ADDR(rd_start), .RD_MAX_ADDR(rd_max), .RD_LENGTH(rd_len), .RD_LEVEL(rd_level),
    .WR_LOAD(wr_load), .WR_START_ADDR(wr_start), .WR_MAX_ADDR(wr_max), .WR_LENGTH(wr_len), .WR_LEVEL(wr_level),
    .REQ(req), .REQ_WRITE(req_write), .REQ_ADDR(req_addr), .REQ_LENGTH(req_length),
    .REQ_ACK(ack1), .REQ_DONE(done1), .RD_GNT(rd_gnt), .WR_GNT(wr_gnt), .FSM_STATE(fsm_state)
  );

  sdram_port_arbiter #(.RR_MODE(0)) dut_fixed (
    .CLK(clk), .RESET(rst),
    .RD_LOAD(rd_load), .RD_START_ADDR(rd_start), .RD_MAX_ADDR(rd_max), .RD_LENGTH(rd_len), .RD_LEVEL(rd_level),
    .WR_LOAD(wr_load), .WR_START_ADDR(wr_start), .WR_MAX_ADDR(wr_max), .WR_LENGTH(wr_len), .WR_LEVEL(wr_level),
    .REQ(req0), .REQ_WRITE(req_write0), .REQ_ADDR(req_addr0), .REQ_LENGTH(req_length0),
    .REQ_ACK(ack0), .REQ_DONE(done0), .RD_GNT(rd_gnt0), .WR_GNT(wr_gnt0), .FSM_STATE(fsm_state0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic apply_levels();
    rd_level = {16'(lvl[1]), 16'(lvl[0])};
    wr_level = {16'(lvl[3]), 16'(lvl[2])};
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_addr[c] = 0; m_start[c] = 0; m_len[c] = 128; m_max[c] = 384000;
    end
    m_ptr = 0;
  endtask

  function automatic bit m_elig(input int c);
    if (m_len[c] == 0) return 1'b0;
    return (c < 2) ? (lvl[c] < m_len[c]) : (lvl[c] >= m_len[c]);
  endfunction

  function automatic int m_pick();
    for (int k = 1; k <= NCH; k++) begin
      int c = (m_ptr + k) % NCH;
      if (m_elig(c)) return c;
    end
    return -1;
  endfunction

  task automatic model_advance(input int c);
    if (m_addr[c] + m_len[c] < m_max[c]) m_addr[c] = m_addr[c] + m_len[c];
    else m_addr[c] = m_start[c];
  endtask

  task automatic set_load(input int c, input int s, input int mx, input int ln);
    if (c < 2) begin
      rd_load[c] = 1'b1;
      rd_start[c*23 +: 23] = 23'(s);
      rd_max[c*23 +: 23]   = 23'(mx);
      rd_len[c*9 +: 9]     = 9'(ln);
    end else begin
      wr_load[c-2] = 1'b1;
      wr_start[(c-2)*23 +: 23] = 23'(s);
      wr_max[(c-2)*23 +: 23]   = 23'(mx);
      wr_len[(c-2)*9 +: 9]     = 9'(ln);
    end
    m_start[c] = s & 'h7FFFFF;
    m_addr[c]  = s & 'h7FFFFF;
    m_max[c]   = mx & 'h7FFFFF;
    m_len[c]   = ln & 'h1FF;
  endtask

  // mode 0: normal burst, 1: load granted channel while busy, 2: reset while busy
  task automatic do_burst(input int mode, output int ch_o, output int addr_o);
    int exp_c, cnt, gap;
    logic [EW-1:0] e;
    logic [3:0] g;
    bit skip_adv;
    ch_o = -1; addr_o = -1; skip_adv = 1'b0;
    exp_c = m_pick();
    if (exp_c < 0) begin
      cnt = 0;
      ack1 = 1'b1; done1 = 1'b1;
      @(negedge clk);
      ack1 = 1'b0; done1 = 1'b0;
      if (req) cnt++;
      repeat (3) begin
        @(negedge clk);
        if (req) cnt++;
      end
      chk("idle_no_req", cnt, 0);
      return;
    end
    exp_q.push_back({1'(exp_c >= 2), 4'(1 << exp_c), 23'(m_addr[exp_c]), 9'(m_len[exp_c])});
    cnt = 0;
    while (!req && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (!req) begin
      chk("req_timeout", 0, 1);
      exp_q.delete();
      return;
    end
    e = exp_q.pop_front();
    chk("req_write", req_write, e[36]);
    chk("gnt", {wr_gnt, rd_gnt}, e[35:32]);
    chk("req_addr", req_addr, e[31:9]);
    chk("req_length", req_length, e[8:0]);
    g = {wr_gnt, rd_gnt};
    ch_o = g[3] ? 3 : g[2] ? 2 : g[1] ? 1 : g[0] ? 0 : -1;
    addr_o = req_addr;
    m_ptr = exp_c;
    repeat ($urandom_range(0, 2)) begin
      done1 = 1'($urandom_range(0, 1));
      @(negedge clk);
      done1 = 1'b0;
    end
    chk("req_hold", {req, req_addr}, {1'b1, e[31:9]});
    if (mode == 0 && $urandom_range(0, 3) == 0) begin
      ack1 = 1'b1; done1 = 1'b1;
      @(negedge clk);
      ack1 = 1'b0; done1 = 1'b0;
    end else begin
      ack1 = 1'b1;
      @(negedge clk);
      ack1 = 1'b0;
      chk("busy_req_low", req, 0);
      if (mode == 1) begin
        set_load(exp_c, 'h100000, 'h200000, m_len[exp_c]);
        @(negedge clk);
        rd_load = '0; wr_load = '0;
        skip_adv = 1'b1;
      end
      if (mode == 2) begin
        lvl = '{'hFFFF, 'hFFFF, 0, 0};
        apply_levels();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("rst_busy_out", {req, fsm_state, rd_gnt, wr_gnt}, 0);
        done1 = 1'b1;
        @(negedge clk);
        done1 = 1'b0;
        chk("rst_done_ignored", {req, fsm_state, rd_gnt, wr_gnt}, 0);
        return;
      end
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      done1 = 1'b1;
      @(negedge clk);
      done1 = 1'b0;
    end
    if (!skip_adv) model_advance(exp_c);
    chk("gnt_cleared", {wr_gnt, rd_gnt}, 0);
  endtask

  task automatic fixed_burst();
    int cnt = 0;
    while (!req0 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("fixed_gnt", {req0, wr_gnt0, rd_gnt0}, 5'b10001);
    ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0; done0 = 1'b1;
    @(negedge clk);
    done0 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, mx, ln, cnt;
    bit any;
    n_chk = 0; n_pass = 0;
    rd_load = '0; wr_load = '0;
    rd_start = '0; rd_max = '0; wr_start = '0; wr_max = '0; rd_len = '0; wr_len = '0;
    ack1 = 1'b0; done1 = 1'b0; ack0 = 1'b0; done0 = 1'b0;
    lvl = '{'hFFFF, 'hFFFF, 0, 0};
    apply_levels();
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {req, req_write, fsm_state, rd_gnt, wr_gnt}, 0);
    chk("reset_addr", req_addr, 0);
    chk("reset_length", req_length, 0);

    // first read request one cycle after eligibility
    lvl[0] = 0;
    apply_levels();
    @(negedge clk);
    chk("lat_req", {req, req_write, rd_gnt, wr_gnt}, 6'b100100);
    chk("lat_addr_len", {req_addr, req_length}, {23'd0, 9'd128});
    do_burst(0, ch, a);

    // long run over RD0 up to the wrap point
    set_load(0, 0, 384000, 128);
    @(negedge clk);
    rd_load = '0;
    for (int i = 0; i <= 3000; i++) begin
      do_burst(0, ch, a);
      if (i == 2999) chk("wrap_last", a, 383872);
      if (i == 3000) chk("wrap_zero", a, 0);
    end

    // round-robin order, starting after a WR1 grant
    lvl = '{'hFFFF, 'hFFFF, 0, 500};
    apply_levels();
    do_burst(0, ch, a);
    chk("rr_seed_wr1", ch, 3);
    lvl = '{0, 0, 500, 500};
    apply_levels();
    for (int i = 0; i < 5; i++) begin
      do_burst(0, ch, a);
      chk("rr_order", ch, exp_order[i]);
    end

    // fixed priority instance always picks RD0
    repeat (3) fixed_burst();
    do_burst(0, ch, a);

    // write threshold at exactly one burst of data
    lvl = '{'hFFFF, 'hFFFF, 127, 0};
    apply_levels();
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (req) cnt++;
    end
    chk("wr127_no_req", cnt, 0);
    lvl[2] = 128;
    apply_levels();
    @(negedge clk);
    chk("wr128_req", {req, req_write, wr_gnt, rd_gnt}, 6'b110100);
    do_burst(0, ch, a);
    chk("wr128_chan", ch, 2);

    // load on the granted channel during the burst replaces the advance
    do_burst(1, ch, a);
    do_burst(0, ch, a);
    chk("wr_load_addr", a, 'h100000);

    // reset in the middle of a burst
    lvl = '{0, 'hFFFF, 0, 0};
    apply_levels();
    do_burst(2, ch, a);
    lvl[0] = 0;
    apply_levels();
    do_burst(0, ch, a);
    chk("post_rst_addr", a, 0);

    // randomized traffic, occasional reloads including zero length and tight max
    for (int it = 0; it < 300; it++) begin
      any = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        for (int c = 0; c < NCH; c++) begin
          if ($urandom_range(0, 1) == 1) begin
            s  = $urandom_range(0, 4000);
            mx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, s) : s + $urandom_range(1, 3000);
            ln = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 511);
            set_load(c, s, mx, ln);
            any = 1'b1;
          end
        end
      end
      for (int c = 0; c < NCH; c++) lvl[c] = $urandom_range(0, 600);
      apply_levels();
      if (any) begin
        @(negedge clk);
        rd_load = '0; wr_load = '0;
      end
      do_burst(0, ch, a);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
